// File: rtl/serial_link_power_sequencer.sv
// Power sequencer for one serial link instance: orders clock-gate enable, soft reset
// release and AXI de-isolation on power-up, and the reverse on power-down.
module serial_link_power_sequencer #(
    parameter int ClkSettleCycles = 8,
    parameter int RstHoldCycles   = 16,
    parameter int IsoTimeout      = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       link_en_i,
    input  logic [1:0] isolated_i,
    input  logic       timeout_clr_i,
    output logic [1:0] isolate_o,
    output logic       clk_ena_o,
    output logic       reset_no,
    output logic       ready_o,
    output logic       busy_o,
    output logic       timeout_o
);

    localparam int MaxTimed  = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
    localparam int MaxCycles = (MaxTimed > IsoTimeout) ? MaxTimed : IsoTimeout;
    localparam int CntWidth  = $clog2(MaxCycles) + 1;

    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(ClkSettleCycles - 1);
    localparam logic [CntWidth-1:0] HoldLoad   = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] IsoLoad    = CntWidth'(IsoTimeout - 1);
    localparam logic [CntWidth-1:0] CntZero    = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0] CntOne     = {{(CntWidth-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_CLK_ON   = 3'd1,
        ST_RST_REL  = 3'd2,
        ST_DEISO    = 3'd3,
        ST_ON       = 3'd4,
        ST_ISO      = 3'd5,
        ST_RST_ASRT = 3'd6,
        ST_CLK_OFF  = 3'd7
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CntWidth-1:0] cnt_r;
    logic [CntWidth-1:0] cnt_s;
    logic                cnt_zero_s;
    logic                timeout_set_s;
    logic [5:0]          out_s;

    // Output vector {isolate[1:0], clk_ena, reset_n, ready, busy} for a given state.
    function automatic logic [5:0] decode_outputs(input state_t st);
        logic [5:0] v;
        case (st)
            ST_OFF:      v = 6'b11_0_0_0_0;
            ST_CLK_ON:   v = 6'b11_1_0_0_1;
            ST_RST_REL:  v = 6'b11_1_1_0_1;
            ST_DEISO:    v = 6'b00_1_1_0_1;
            ST_ON:       v = 6'b00_1_1_1_0;
            ST_ISO:      v = 6'b11_1_1_0_1;
            ST_RST_ASRT: v = 6'b11_1_0_0_1;
            ST_CLK_OFF:  v = 6'b11_1_0_0_1;
            default:     v = 6'b11_0_0_0_0;
        endcase
        return v;
    endfunction

    assign cnt_zero_s = (cnt_r == CntZero);
    assign out_s      = decode_outputs(state_s);

    // Next-state selection; link_en_i only matters in the two stable states.
    always_comb begin
        state_s       = state_r;
        timeout_set_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (link_en_i) state_s = ST_CLK_ON;
                else           state_s = ST_OFF;
            end
            ST_CLK_ON: begin
                if (cnt_zero_s) state_s = ST_RST_REL;
                else            state_s = ST_CLK_ON;
            end
            ST_RST_REL: begin
                if (cnt_zero_s) state_s = ST_DEISO;
                else            state_s = ST_RST_REL;
            end
            ST_DEISO: begin
                // A matching handshake on the final count wins over the timeout.
                if (isolated_i == 2'b00) begin
                    state_s = ST_ON;
                end else if (cnt_zero_s) begin
                    state_s       = ST_ON;
                    timeout_set_s = 1'b1;
                end else begin
                    state_s = ST_DEISO;
                end
            end
            ST_ON: begin
                if (!link_en_i) state_s = ST_ISO;
                else            state_s = ST_ON;
            end
            ST_ISO: begin
                if (isolated_i == 2'b11) begin
                    state_s = ST_RST_ASRT;
                end else if (cnt_zero_s) begin
                    state_s       = ST_RST_ASRT;
                    timeout_set_s = 1'b1;
                end else begin
                    state_s = ST_ISO;
                end
            end
            ST_RST_ASRT: begin
                if (cnt_zero_s) state_s = ST_CLK_OFF;
                else            state_s = ST_RST_ASRT;
            end
            ST_CLK_OFF: begin
                if (cnt_zero_s) state_s = ST_OFF;
                else            state_s = ST_CLK_OFF;
            end
            default: begin
                state_s = ST_OFF;
            end
        endcase
    end

    // Down-counter: reload N-1 on every state entry so residency is exactly N cycles.
    always_comb begin
        cnt_s = cnt_r;
        if (state_s != state_r) begin
            case (state_s)
                ST_CLK_ON, ST_CLK_OFF:  cnt_s = SettleLoad;
                ST_RST_REL, ST_RST_ASRT: cnt_s = HoldLoad;
                ST_DEISO, ST_ISO:       cnt_s = IsoLoad;
                default:                cnt_s = CntZero;
            endcase
        end else if (!cnt_zero_s) begin
            cnt_s = cnt_r - CntOne;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, counter and Moore outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_OFF;
            cnt_r     <= CntZero;
            isolate_o <= 2'b11;
            clk_ena_o <= 1'b0;
            reset_no  <= 1'b0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            isolate_o <= out_s[5:4];
            clk_ena_o <= out_s[3];
            reset_no  <= out_s[2];
            ready_o   <= out_s[1];
            busy_o    <= out_s[0];
            if (timeout_set_s)      timeout_o <= 1'b1;
            else if (timeout_clr_i) timeout_o <= 1'b0;
            else                    timeout_o <= timeout_o;
        end
    end

endmodule

// File: tb/tb_serial_link_power_sequencer.sv
// Directed bench for serial_link_power_sequencer with a delayed-echo isolator model
// and hand-computed per-edge expectations.
module tb_serial_link_power_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       link_en_i;
    logic [1:0] isolated_i;
    logic       timeout_clr_i;
    logic [1:0] isolate_o;
    logic       clk_ena_o;
    logic       reset_no;
    logic       ready_o;
    logic       busy_o;
    logic       timeout_o;

    int total = 0;
    int bad   = 0;
    int inv_viol = 0;

    logic [6:0] obs;
    logic [6:0] exp_v;
    localparam logic [6:0] RST_V = 7'b11_0_0_0_0_0;

    // Isolator model: echoes isolate_o back iso_dly edges later, unless forced.
    logic [1:0] iso_hist [0:3];
    int         iso_dly = 2;
    logic       iso_force = 1'b0;
    logic [1:0] iso_force_val = 2'b00;

    serial_link_power_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .link_en_i    (link_en_i),
        .isolated_i   (isolated_i),
        .timeout_clr_i(timeout_clr_i),
        .isolate_o    (isolate_o),
        .clk_ena_o    (clk_ena_o),
        .reset_no     (reset_no),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {isolate_o, clk_ena_o, reset_no, ready_o, busy_o, timeout_o};

    always @(posedge clk_i) begin
        #1;
        for (int i = 3; i > 0; i--) iso_hist[i] = iso_hist[i-1];
        iso_hist[0] = isolate_o;
        isolated_i  = iso_force ? iso_force_val : iso_hist[iso_dly];
    end

    // Ordering invariants sampled every cycle.
    always @(negedge clk_i) begin
        if ((isolate_o != 2'b11 && !reset_no) || (!clk_ena_o && reset_no))
            inv_viol = inv_viol + 1;
    end

    task automatic test_reset();
        rst_i = 1'b1;
        link_en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        total++;
        if (obs !== RST_V) begin
            bad++;
            $display("FAIL reset_vals got=%b exp=%b", obs, RST_V);
        end
        rst_i = 1'b0;
        for (int e = 0; e < 100; e++) begin
            @(negedge clk_i);
            total++;
            if (obs !== RST_V) begin
                bad++;
                $display("FAIL idle_off e=%0d got=%b exp=%b", e, obs, RST_V);
            end
        end
    endtask

    task automatic test_power_up();
        iso_dly = 2;
        iso_force = 1'b0;
        link_en_i = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            @(negedge clk_i);
            exp_v = {(e >= 24) ? 2'b00 : 2'b11, 1'b1, (e >= 8), (e >= 27), (e < 27), 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL power_up e=%0d got=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_power_down();
        iso_dly = 1;
        link_en_i = 1'b0;
        for (int e = 0; e <= 29; e++) begin
            @(negedge clk_i);
            exp_v = {2'b11, (e < 26), (e < 2), 1'b0, (e < 26), 1'b0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL power_down e=%0d got=%b exp=%b", e, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        iso_force = 1'b1;
        iso_force_val = 2'b01;
        link_en_i = 1'b1;
        for (int e = 0; e <= 1050; e++) begin
            @(negedge clk_i);
            timeout_clr_i = (e == 1047);
            exp_v = 7'b0;
            if (e == 23)                 exp_v = 7'b11_1_1_0_1_0;
            else if (e == 24 || e == 1047) exp_v = 7'b00_1_1_0_1_0;
            else if (e == 1048 || e == 1050) exp_v = 7'b00_1_1_1_0_1;
            if (e == 23 || e == 24 || e == 1047 || e == 1048 || e == 1050) begin
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL deiso_timeout e=%0d got=%b exp=%b", e, obs, exp_v);
                end
            end
        end
        timeout_clr_i = 1'b1;
        @(negedge clk_i);
        timeout_clr_i = 1'b0;
        total++;
        if (obs !== 7'b00_1_1_1_0_0) begin
            bad++;
            $display("FAIL timeout_clear got=%b exp=%b", obs, 7'b00_1_1_1_0_0);
        end
        // Power-down where 11 arrives exactly on the final count: no timeout.
        iso_force_val = 2'b10;
        link_en_i = 1'b0;
        for (int e = 0; e <= 1048; e++) begin
            @(negedge clk_i);
            if (e == 1022) iso_force_val = 2'b11;
            exp_v = 7'b0;
            if (e == 1023)      exp_v = 7'b11_1_1_0_1_0;
            else if (e == 1024 || e == 1047) exp_v = 7'b11_1_0_0_1_0;
            else if (e == 1048) exp_v = RST_V;
            if (e == 1023 || e == 1024 || e == 1047 || e == 1048) begin
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL iso_boundary e=%0d got=%b exp=%b", e, obs, exp_v);
                end
            end
        end
        iso_force = 1'b0;
    endtask

    task automatic test_toggle();
        iso_dly = 1;
        inv_viol = 0;
        link_en_i = 1'b1;
        for (int e = 0; e <= 60; e++) begin
            @(negedge clk_i);
            if (e == 3) link_en_i = 1'b0;
            total++;
            if (ready_o !== (e == 26)) begin
                bad++;
                $display("FAIL toggle_ready e=%0d got=%b exp=%b", e, ready_o, (e == 26));
            end
            if (e == 27 || e == 52 || e == 53 || e == 60) begin
                if (e == 27)      exp_v = 7'b11_1_1_0_1_0;
                else if (e == 52) exp_v = 7'b11_1_0_0_1_0;
                else              exp_v = RST_V;
                total++;
                if (obs !== exp_v) begin
                    bad++;
                    $display("FAIL toggle_seq e=%0d got=%b exp=%b", e, obs, exp_v);
                end
            end
        end
        total++;
        if (inv_viol !== 0) begin
            bad++;
            $display("FAIL ordering_invariant got=%0d exp=0", inv_viol);
        end
    endtask

    task automatic test_reset_mid();
        link_en_i = 1'b1;
        for (int e = 0; e <= 11; e++) @(negedge clk_i);
        total++;
        if (obs !== 7'b11_1_1_0_1_0) begin
            bad++;
            $display("FAIL pre_reset_rst_rel got=%b exp=%b", obs, 7'b11_1_1_0_1_0);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (obs !== RST_V) begin
            bad++;
            $display("FAIL reset_mid got=%b exp=%b", obs, RST_V);
        end
        rst_i = 1'b0;
        link_en_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (obs !== RST_V) begin
            bad++;
            $display("FAIL after_reset_off got=%b exp=%b", obs, RST_V);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) iso_hist[i] = 2'b11;
        isolated_i = 2'b11;
        rst_i = 1'b1;
        link_en_i = 1'b0;
        timeout_clr_i = 1'b0;
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
